// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster and animation bundle between the timing
// generator (master) and the sprite renderers / connector (slave).
interface vga_timing_gen_if #(
    parameter int AW = 3
);
    logic          anim_en;
    logic          anim_restart;
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic          blank;
    logic          hs;
    logic          vs;
    logic          frame_tick;
    logic [AW-1:0] anim_frame;
    logic          anim_tick;
    logic          anim_last;

    modport master (
        input  anim_en, anim_restart,
        output DrawX, DrawY, blank, hs, vs, frame_tick,
        output anim_frame, anim_tick, anim_last
    );

    modport slave (
        output anim_en, anim_restart,
        input  DrawX, DrawY, blank, hs, vs, frame_tick,
        input  anim_frame, anim_tick, anim_last
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing plus animation frame index.
// Define VGA_PIPE_ALIGN_EN to delay hs/vs/blank by one register stage.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_TOTAL     = 800,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_TOTAL     = 525,
    parameter int FRAME_DIV   = 6,
    parameter int ANIM_FRAMES = 8,
    parameter bit ANIM_LOOP   = 1'b1
) (
    input logic              vga_clk,
    input logic              reset_n,
    vga_timing_gen_if.master vga
);
    localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [AW-1:0] A_LAST = AW'(ANIM_FRAMES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(FRAME_DIV - 1);

    logic [9:0]    hc;
    logic [9:0]    vc;
    logic [9:0]    hc_nxt;
    logic [9:0]    vc_nxt;
    logic          hs_d;
    logic          vs_d;
    logic          blank_d;
    logic          tick_d;
    logic          hs_q;
    logic          vs_q;
    logic          blank_q;
    logic          tick_q;
    logic [CW-1:0] frame_cnt;
    logic [AW-1:0] anim_frame;
    logic [AW-1:0] anim_nxt;
    logic          anim_tick;
    logic          anim_busy;
    logic          step;

    // Next raster position: pixel wrap advances the line, line wrap the frame.
    always_comb begin
        hc_nxt = hc + 10'd1;
        vc_nxt = vc;
        if (hc == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (vc == V_LAST) ? '0 : vc + 10'd1;
        end
    end

    // Decode from the next position so registered flags line up with DrawX/DrawY.
    always_comb begin
        hs_d    = !((hc_nxt >= HS_ON) && (hc_nxt < HS_OFF));
        vs_d    = !((vc_nxt >= VS_ON) && (vc_nxt < VS_OFF));
        blank_d = (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
        tick_d  = (hc_nxt == '0) && (vc_nxt == V_VIS);
    end

    // Raster counters and glitch-free registered timing flags.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc      <= '0;
            vc      <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            hc      <= hc_nxt;
            vc      <= vc_nxt;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    // A saturated non-looping sequence stops counting frames altogether.
    always_comb begin
        anim_busy = ANIM_LOOP || (anim_frame != A_LAST);
        step      = vga.anim_en && tick_q && anim_busy;
        anim_nxt  = (anim_frame == A_LAST) ? '0 : anim_frame + 1'b1;
    end

    // Animation divider and frame index; restart wins over a frame tick.
    always_ff @(posedge vga_clk) begin
        if (!reset_n || vga.anim_restart) begin
            frame_cnt  <= '0;
            anim_frame <= '0;
            anim_tick  <= 1'b0;
        end else begin
            anim_tick <= 1'b0;
            if (step) begin
                if (frame_cnt == C_LAST) begin
                    frame_cnt  <= '0;
                    anim_frame <= anim_nxt;
                    anim_tick  <= (anim_nxt != anim_frame);
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

`ifdef VGA_PIPE_ALIGN_EN
    logic hs_p;
    logic vs_p;
    logic blank_p;

    // Extra stage matching sprite blocks that register their palette output.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hs_p    <= 1'b1;
            vs_p    <= 1'b1;
            blank_p <= 1'b0;
        end else begin
            hs_p    <= hs_q;
            vs_p    <= vs_q;
            blank_p <= blank_q;
        end
    end

    assign vga.hs    = hs_p;
    assign vga.vs    = vs_p;
    assign vga.blank = blank_p;
`else
    assign vga.hs    = hs_q;
    assign vga.vs    = vs_q;
    assign vga.blank = blank_q;
`endif

    assign vga.DrawX      = hc;
    assign vga.DrawY      = vc;
    assign vga.frame_tick = tick_q;
    assign vga.anim_frame = anim_frame;
    assign vga.anim_tick  = anim_tick;
    assign vga.anim_last  = (anim_frame == A_LAST);
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen using a small
// raster (looping and saturating) plus one full-size instance.
module tb_vga_timing_gen;
    typedef struct {
        int hv, hfp, hsw, ht, vv, vfp, vsw, vt, div, nf;
        bit loop;
    } cfg_t;

    typedef struct {
        int x, y, fc, af;
        bit at, ft;
        bit phs, pvs, pbl;
    } ms_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       bl, hs, vs, ft;
        logic [2:0] af;
        logic       at, al;
    } obs_t;

    typedef struct packed {
        logic [1:0] id;
        obs_t       o;
    } sb_t;

    logic clk;
    logic rst_n;
    logic en;
    logic rs;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int at_l  = 0;
    int at_s  = 0;
    int ft_l  = 0;
    int vs_l  = 0;
    int bl_l  = 0;

    cfg_t cL = '{16, 2, 4, 26, 6, 1, 2, 11, 6, 8, 1'b1};
    cfg_t cS = '{16, 2, 4, 26, 6, 1, 2, 11, 6, 8, 1'b0};
    cfg_t cD = '{640, 16, 96, 800, 480, 10, 2, 525, 6, 8, 1'b1};
    ms_t  mL, mS, mD;
    sb_t  q[$];

    vga_timing_gen_if ifL ();
    vga_timing_gen_if ifS ();
    vga_timing_gen_if ifD ();

    assign ifL.anim_en = en;
    assign ifS.anim_en = en;
    assign ifD.anim_en = en;
    assign ifL.anim_restart = rs;
    assign ifS.anim_restart = rs;
    assign ifD.anim_restart = rs;

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_TOTAL(26),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_TOTAL(11),
        .FRAME_DIV(6), .ANIM_FRAMES(8), .ANIM_LOOP(1'b1)
    ) u_l (.vga_clk(clk), .reset_n(rst_n), .vga(ifL.master));

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_TOTAL(26),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_TOTAL(11),
        .FRAME_DIV(6), .ANIM_FRAMES(8), .ANIM_LOOP(1'b0)
    ) u_s (.vga_clk(clk), .reset_n(rst_n), .vga(ifS.master));

    vga_timing_gen u_d (.vga_clk(clk), .reset_n(rst_n), .vga(ifD.master));

    obs_t oL, oS, oD;
    assign oL = {ifL.DrawX, ifL.DrawY, ifL.blank, ifL.hs, ifL.vs,
                 ifL.frame_tick, ifL.anim_frame, ifL.anim_tick, ifL.anim_last};
    assign oS = {ifS.DrawX, ifS.DrawY, ifS.blank, ifS.hs, ifS.vs,
                 ifS.frame_tick, ifS.anim_frame, ifS.anim_tick, ifS.anim_last};
    assign oD = {ifD.DrawX, ifD.DrawY, ifD.blank, ifD.hs, ifD.vs,
                 ifD.frame_tick, ifD.anim_frame, ifD.anim_tick, ifD.anim_last};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit hs_of(int x, cfg_t c);
        return !(x >= c.hv + c.hfp && x < c.hv + c.hfp + c.hsw);
    endfunction

    function automatic bit vs_of(int y, cfg_t c);
        return !(y >= c.vv + c.vfp && y < c.vv + c.vfp + c.vsw);
    endfunction

    function automatic bit bl_of(int x, int y, cfg_t c);
        return (x < c.hv) && (y < c.vv);
    endfunction

    function automatic ms_t mstep(ms_t s, cfg_t c, bit rst, bit e, bit r);
        ms_t n;
        n = s;
        n.phs = hs_of(s.x, c);
        n.pvs = vs_of(s.y, c);
        n.pbl = bl_of(s.x, s.y, c);
        if (!rst) begin
            n.x = 0; n.y = 0; n.fc = 0; n.af = 0;
            n.at = 0; n.ft = 0;
            n.phs = 1; n.pvs = 1; n.pbl = 0;
            return n;
        end
        n.at = 0;
        if (r) begin
            n.fc = 0;
            n.af = 0;
        end else if (e && s.ft && (c.loop || s.af != c.nf - 1)) begin
            if (s.fc == c.div - 1) begin
                n.fc = 0;
                n.af = (s.af + 1) % c.nf;
                n.at = (n.af != s.af);
            end else begin
                n.fc = s.fc + 1;
            end
        end
        n.x = s.x + 1;
        if (n.x == c.ht) begin
            n.x = 0;
            n.y = s.y + 1;
            if (n.y == c.vt) n.y = 0;
        end
        n.ft = (n.x == 0) && (n.y == c.vv);
        return n;
    endfunction

    function automatic obs_t exp_of(ms_t s, cfg_t c);
        obs_t o;
        o.x  = 10'(s.x);
        o.y  = 10'(s.y);
`ifdef VGA_PIPE_ALIGN_EN
        o.bl = s.pbl;
        o.hs = s.phs;
        o.vs = s.pvs;
`else
        o.bl = bl_of(s.x, s.y, c);
        o.hs = hs_of(s.x, c);
        o.vs = vs_of(s.y, c);
`endif
        o.ft = s.ft;
        o.af = 3'(s.af);
        o.at = s.at;
        o.al = (s.af == c.nf - 1);
        return o;
    endfunction

    task automatic chk_i(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        sb_t  e;
        obs_t got;
        string tag;
        mL = mstep(mL, cL, rst_n, en, rs);
        mS = mstep(mS, cS, rst_n, en, rs);
        mD = mstep(mD, cD, rst_n, en, rs);
        q.push_back({2'd0, exp_of(mL, cL)});
        q.push_back({2'd1, exp_of(mS, cS)});
        q.push_back({2'd2, exp_of(mD, cD)});
        if (rst_n) ncyc++;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.id)
                2'd0:    begin got = oL; tag = "loop"; end
                2'd1:    begin got = oS; tag = "sat";  end
                default: begin got = oD; tag = "full"; end
            endcase
            total++;
            assert (got === e.o) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, got, e.o);
            end
        end
        if (ifL.anim_tick) at_l++;
        if (ifS.anim_tick) at_s++;
        if (ifL.frame_tick) ft_l++;
        if (!ifL.vs) vs_l++;
        if (ifL.blank) bl_l++;
    endtask

    task automatic wait_ft();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!ifL.frame_tick && n < 400);
        chk_i("ft_wait", int'(ifL.frame_tick), 1);
    endtask

    initial begin
        int first;
        int hcnt;
        int base;
        int n;
        rst_n = 1'b0;
        en    = 1'b1;
        rs    = 1'b0;
        repeat (3) cyc();
        chk_i("rst_x", int'(ifD.DrawX), 0);
        chk_i("rst_hs", int'(ifD.hs), 1);
        rst_n = 1'b1;
        at_l = 0;
        at_s = 0;

        // one full-size line
        first = -1;
        hcnt  = 0;
        repeat (810) begin
            cyc();
            if (ifD.DrawY == 10'd0 && !ifD.hs) begin
                hcnt++;
                if (first < 0) first = int'(ifD.DrawX);
            end
        end
        chk_i("d_hs_len", hcnt, 96);
`ifdef VGA_PIPE_ALIGN_EN
        chk_i("d_hs_start", first, 657);
`else
        chk_i("d_hs_start", first, 656);
`endif

        // one small frame window
        vs_l = 0; bl_l = 0; ft_l = 0;
        repeat (286) cyc();
        chk_i("l_vs_cnt", vs_l, 52);
        chk_i("l_bl_cnt", bl_l, 96);
        chk_i("l_ft_cnt", ft_l, 1);

        // 60 small frames since reset release
        while (ncyc < 17160) cyc();
        chk_i("l_ticks", at_l, 10);
        chk_i("l_frame", int'(ifL.anim_frame), 2);
        chk_i("s_ticks", at_s, 7);
        chk_i("s_frame", int'(ifS.anim_frame), 7);
        chk_i("s_last", int'(ifS.anim_last), 1);

        // restart coincident with the tick that completes a step
        repeat (6) wait_ft();
        base = at_l;
        rs = 1'b1;
        cyc();
        rs = 1'b0;
        chk_i("rs_frame", int'(ifL.anim_frame), 0);
        chk_i("rs_tick", int'(ifL.anim_tick), 0);
        repeat (5) cyc();
        chk_i("rs_no_tick", at_l - base, 0);

        // hold for 12 frames
        en = 1'b0;
        repeat (12 * 286) cyc();
        chk_i("hold_frame", int'(ifL.anim_frame), 0);
        chk_i("hold_ticks", at_l - base, 0);
        en = 1'b1;
        repeat (7 * 286) cyc();
        chk_i("resume_ticks", at_l - base, 1);
        chk_i("resume_frame", int'(ifL.anim_frame), 1);

        // reset mid-line, mid-frame
        n = 0;
        while (!(ifL.DrawX == 10'd10 && ifL.DrawY == 10'd3) && n < 400) begin
            cyc();
            n++;
        end
        chk_i("pos_wait", int'(ifL.DrawX == 10'd10 && ifL.DrawY == 10'd3), 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk_i("mid_x", int'(ifL.DrawX), 0);
        chk_i("mid_y", int'(ifL.DrawY), 0);
        chk_i("mid_hs", int'(ifL.hs), 1);
        chk_i("mid_vs", int'(ifL.vs), 1);
        chk_i("mid_af", int'(ifL.anim_frame), 0);
        repeat (30) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA raster timing on the pixel clock. Drives DrawX/DrawY/blank to the sprite renderers and hs/vs to the connector. Also maintains an animation frame index that steps every FRAME_DIV video frames. Sprite ROM address logic uses this index to play multi-frame sprites, e.g. the death sequence.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_TOTAL, 800, pixels per line including blanking
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_TOTAL, 525, lines per frame including blanking
FRAME_DIV, 6, video frames per animation step (>=1)
ANIM_FRAMES, 8, number of animation frames (>=1)
ANIM_LOOP, 1, 1 = wrap to frame 0 after last; 0 = hold on last frame

Ports:
vga_clk  in  1  pixel clock (25 MHz nominal)
reset_n  in  1  synchronous active-low reset
anim_en  in  1  1 = animation counters advance on frame ticks; 0 = hold
anim_restart  in  1  synchronous clear of animation counters
DrawX  out  10  current pixel column (0..H_TOTAL-1)
DrawY  out  10  current line (0..V_TOTAL-1)
blank  out  1  1 = visible region (pixel may be driven); 0 = blanking
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active low
frame_tick  out  1  one-cycle pulse at first blanking line
anim_frame  out  3  current animation frame index (clog2(ANIM_FRAMES), min 1)
anim_tick  out  1  one-cycle pulse when anim_frame changes
anim_last  out  1  anim_frame == ANIM_FRAMES-1

Behaviour:
- Reset (reset_n low at posedge): hc=vc=0, DrawX=DrawY=0, blank=1, hs=1, vs=1, frame_tick=0, frame_cnt=0, anim_frame=0, anim_tick=0. Reset mid-line or mid-frame restarts the raster at (0,0) on the next edge.
- hc increments every cycle. At hc==H_TOTAL-1, hc->0 and vc increments. At vc==V_TOTAL-1 with the line wrap, vc->0.
- DrawX=hc and DrawY=vc, both registered.
- hs, vs, blank and frame_tick are registered and decoded from next-state counters, so they are coincident with DrawX/DrawY; no combinational glitches.
- hs=0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
- vs=0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
- blank=1 iff hc<H_VISIBLE and vc<V_VISIBLE.
- frame_tick=1 for exactly the cycle where hc==0 and vc==V_VISIBLE (line 480): once per 420000 cycles.
- Animation counting:
  - frame_cnt counts frame_ticks while anim_en=1; range 0..FRAME_DIV-1.
  - On a tick with frame_cnt==FRAME_DIV-1: frame_cnt->0 and anim_frame advances.
  - Advance when ANIM_LOOP=1: anim_frame+1, wrapping ANIM_FRAMES-1 -> 0.
  - Advance when ANIM_LOOP=0: anim_frame+1 saturating at ANIM_FRAMES-1; once saturated, frame_cnt and anim_tick stay idle.
  - anim_tick pulses one cycle (registered) only when anim_frame actually changes.
- anim_en=0: frame_cnt and anim_frame hold; raster is unaffected.
- anim_restart=1: frame_cnt=0, anim_frame=0, anim_tick=0 next edge; has priority over a coincident frame_tick.
- anim_last is combinational from anim_frame.

Optional Feature:
Macro VGA_PIPE_ALIGN_EN.
- Defined: hs, vs and blank pass through one extra register stage (reset values 1, 1, 0). They then align with sprite blocks that register the palette output one cycle after DrawX/DrawY. DrawX, DrawY, frame_tick and the animation outputs are not delayed.
- Undefined: no extra stage; timing exactly as in Behaviour.

Test Plan:
- Release reset, run 800 cycles -> DrawX 0..799 then 0, DrawY steps 0->1 at cycle 800; hs low for exactly 96 cycles starting at DrawX=656.
- Run a full frame of 420000 cycles -> vs low only for DrawY 490..491 (1600 cycles); blank high for exactly 640*480=307200 cycles; one frame_tick at (0,480).
- FRAME_DIV=6, ANIM_FRAMES=8, ANIM_LOOP=1, anim_en=1 -> anim_tick every 6 frame_ticks; anim_frame 0..7 then 0; anim_last high during frame 7.
- ANIM_LOOP=0, run 60 frames -> anim_frame stops at 7 after 42 frames, anim_tick count=7, anim_last stays 1.
- Assert anim_restart in the same cycle as the frame_tick completing a step -> anim_frame=0, frame_cnt=0, no anim_tick; drop anim_en for 12 frames -> anim_frame unchanged.
- Assert reset_n low at DrawX=300, DrawY=200 for 1 cycle -> next cycle DrawX=0, DrawY=0, hs=vs=1, anim_frame=0; with VGA_PIPE_ALIGN_EN, hs falls at DrawX=657.
